// File: rtl/control_setare_if.sv
// Bus between the button/clock datapath and the control_setare setting controller.
interface control_setare_if;
   logic       scurt_1, scurt_2, scurt_3;
   logic       lung_1, lung_2, lung_3;
   logic       suna;
   logic [4:0] cur_ora, alarm_ora;
   logic [5:0] cur_min, alarm_min;
   logic [2:0] mod;
   logic [4:0] ed_ora;
   logic [5:0] ed_min;
   logic       load_time, load_alarm, alarm_en, stop_alarm;

   modport master (
      output scurt_1, scurt_2, scurt_3, lung_1, lung_2, lung_3, suna,
             cur_ora, cur_min, alarm_ora, alarm_min,
      input  mod, ed_ora, ed_min, load_time, load_alarm, alarm_en, stop_alarm
   );

   modport slave (
      input  scurt_1, scurt_2, scurt_3, lung_1, lung_2, lung_3, suna,
             cur_ora, cur_min, alarm_ora, alarm_min,
      output mod, ed_ora, ed_min, load_time, load_alarm, alarm_en, stop_alarm
   );
endinterface

// File: rtl/control_setare.sv
// Button-driven time/alarm setting controller for the alarm clock.
// Optional idle abort in set states enabled by defining SETARE_TIMEOUT_EN.
module control_setare #(
   parameter logic [15:0] TIMEOUT_CYC = 16'd60000
) (
   input logic             clock,
   input logic             reset,
   control_setare_if.slave bus
);
   localparam int unsigned ORA_W = 5;
   localparam int unsigned MIN_W = 6;
   localparam int unsigned CNT_W = 16;
   localparam logic [ORA_W-1:0] ORA_MAX = 5'd23;
   localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;

   localparam logic [2:0] NORMAL = 3'd0;
   localparam logic [2:0] T_ORA  = 3'd1;
   localparam logic [2:0] T_MIN  = 3'd2;
   localparam logic [2:0] A_ORA  = 3'd3;
   localparam logic [2:0] A_MIN  = 3'd4;

   localparam logic [2:0] ACT_NONE = 3'd0;
   localparam logic [2:0] ACT_L1   = 3'd1;
   localparam logic [2:0] ACT_L2   = 3'd2;
   localparam logic [2:0] ACT_L3   = 3'd3;
   localparam logic [2:0] ACT_S1   = 3'd4;
   localparam logic [2:0] ACT_S2   = 3'd5;
   localparam logic [2:0] ACT_S3   = 3'd6;

   logic [2:0]       state_q, state_d;
   logic [ORA_W-1:0] ora_q, ora_d;
   logic [MIN_W-1:0] min_q, min_d;
   logic             en_q, en_d;
   logic             lt_q, lt_d, la_q, la_d, sa_q, sa_d;
   logic [2:0]       act;
   logic             timeout_c;

   function automatic logic [ORA_W-1:0] clamp_ora(input logic [ORA_W-1:0] v);
      return (v > ORA_MAX) ? '0 : v;
   endfunction

   function automatic logic [MIN_W-1:0] clamp_min(input logic [MIN_W-1:0] v);
      return (v > MIN_MAX) ? '0 : v;
   endfunction

   // Single winning action per cycle: long before short, lower button first.
   always_comb begin
      act = ACT_NONE;
      if      (bus.lung_1)  act = ACT_L1;
      else if (bus.lung_2)  act = ACT_L2;
      else if (bus.lung_3)  act = ACT_L3;
      else if (bus.scurt_1) act = ACT_S1;
      else if (bus.scurt_2) act = ACT_S2;
      else if (bus.scurt_3) act = ACT_S3;
   end

`ifdef SETARE_TIMEOUT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Idle counter only advances in a set state with no pulse at all.
   always_comb begin
      cnt_d     = '0;
      timeout_c = 1'b0;
      if (state_q != NORMAL && act == ACT_NONE) begin
         if (cnt_q == TIMEOUT_CYC - 16'd1) timeout_c = 1'b1;
         else                              cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end
`else
   logic unused_timeout;
   assign unused_timeout = ^{TIMEOUT_CYC, CNT_W'(0)};
   assign timeout_c      = 1'b0;
`endif

   // Next-state and registered-output computation.
   always_comb begin
      state_d = state_q;
      ora_d   = ora_q;
      min_d   = min_q;
      en_d    = en_q;
      lt_d    = 1'b0;
      la_d    = 1'b0;
      sa_d    = 1'b0;
      case (state_q)
         NORMAL: begin
            if (bus.suna) begin
               sa_d = (act != ACT_NONE);
            end else begin
               case (act)
                  ACT_L1: begin
                     state_d = T_ORA;
                     ora_d   = clamp_ora(bus.cur_ora);
                     min_d   = clamp_min(bus.cur_min);
                  end
                  ACT_L2: begin
                     state_d = A_ORA;
                     ora_d   = clamp_ora(bus.alarm_ora);
                     min_d   = clamp_min(bus.alarm_min);
                  end
                  ACT_S3:  en_d = ~en_q;
                  default: ;
               endcase
            end
         end
         T_ORA, A_ORA: begin
            case (act)
               ACT_L1:  state_d = NORMAL;
               ACT_S1:  state_d = (state_q == T_ORA) ? T_MIN : A_MIN;
               ACT_S2:  ora_d = (ora_q >= ORA_MAX) ? '0 : ora_q + ORA_W'(1);
               ACT_S3:  ora_d = (ora_q == '0) ? ORA_MAX : ora_q - ORA_W'(1);
               default: if (timeout_c) state_d = NORMAL;
            endcase
         end
         T_MIN, A_MIN: begin
            case (act)
               ACT_L1: state_d = NORMAL;
               ACT_S1: begin
                  state_d = NORMAL;
                  lt_d    = (state_q == T_MIN);
                  la_d    = (state_q == A_MIN);
                  if (state_q == A_MIN) en_d = 1'b1;
               end
               ACT_S2:  min_d = (min_q >= MIN_MAX) ? '0 : min_q + MIN_W'(1);
               ACT_S3:  min_d = (min_q == '0) ? MIN_MAX : min_q - MIN_W'(1);
               default: if (timeout_c) state_d = NORMAL;
            endcase
         end
         default: state_d = NORMAL;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= NORMAL;
         ora_q   <= '0;
         min_q   <= '0;
         en_q    <= 1'b0;
         lt_q    <= 1'b0;
         la_q    <= 1'b0;
         sa_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         ora_q   <= ora_d;
         min_q   <= min_d;
         en_q    <= en_d;
         lt_q    <= lt_d;
         la_q    <= la_d;
         sa_q    <= sa_d;
      end
   end

   assign bus.mod        = state_q;
   assign bus.ed_ora     = ora_q;
   assign bus.ed_min     = min_q;
   assign bus.alarm_en   = en_q;
   assign bus.load_time  = lt_q;
   assign bus.load_alarm = la_q;
   assign bus.stop_alarm = sa_q;
endmodule

// File: tb/tb_control_setare.sv
// Scoreboard bench for control_setare: directed steps push expectations, a monitor checks them.
module tb_control_setare;
   logic clock = 1'b0;
   logic reset = 1'b1;
   control_setare_if bus();

   control_setare #(.TIMEOUT_CYC(16'd16)) dut (.clock(clock), .reset(reset), .bus(bus));

   always #5 clock = ~clock;

   localparam logic [5:0] NONE = 6'b000000;
   localparam logic [5:0] L1   = 6'b100000;
   localparam logic [5:0] L2   = 6'b010000;
   localparam logic [5:0] L3   = 6'b001000;
   localparam logic [5:0] S1   = 6'b000100;
   localparam logic [5:0] S2   = 6'b000010;
   localparam logic [5:0] S3   = 6'b000001;

   typedef struct {
      string      name;
      logic [2:0] mod;
      logic [4:0] ora;
      logic [5:0] min;
      logic       lt, la, ae, sa;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   logic [4:0] cur_o = 5'd12, alm_o = 5'd7;
   logic [5:0] cur_m = 6'd34, alm_m = 6'd0;

   task automatic step(input string name, input logic rst, input logic [5:0] p, input logic sn,
                       input logic [2:0] e_mod, input logic [4:0] e_ora, input logic [5:0] e_min,
                       input logic e_lt, input logic e_la, input logic e_ae, input logic e_sa);
      exp_t e;
      @(negedge clock);
      reset       = rst;
      bus.lung_1  = p[5]; bus.lung_2  = p[4]; bus.lung_3  = p[3];
      bus.scurt_1 = p[2]; bus.scurt_2 = p[1]; bus.scurt_3 = p[0];
      bus.suna    = sn;
      bus.cur_ora = cur_o; bus.cur_min = cur_m;
      bus.alarm_ora = alm_o; bus.alarm_min = alm_m;
      e.name = name; e.mod = e_mod; e.ora = e_ora; e.min = e_min;
      e.lt = e_lt; e.la = e_la; e.ae = e_ae; e.sa = e_sa;
      exp_q.push_back(e);
   endtask

   // Monitor: one expectation per clocked step, checked just after the edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clock);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (bus.mod !== e.mod || bus.ed_ora !== e.ora || bus.ed_min !== e.min ||
                bus.load_time !== e.lt || bus.load_alarm !== e.la ||
                bus.alarm_en !== e.ae || bus.stop_alarm !== e.sa) begin
               n_err++;
               $display("FAIL %s: got mod=%0d ed=%0d:%0d lt=%b la=%b ae=%b sa=%b, want mod=%0d ed=%0d:%0d lt=%b la=%b ae=%b sa=%b",
                        e.name, bus.mod, bus.ed_ora, bus.ed_min, bus.load_time, bus.load_alarm,
                        bus.alarm_en, bus.stop_alarm, e.mod, e.ora, e.min, e.lt, e.la, e.ae, e.sa);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      bus.lung_1 = 0; bus.lung_2 = 0; bus.lung_3 = 0;
      bus.scurt_1 = 0; bus.scurt_2 = 0; bus.scurt_3 = 0; bus.suna = 0;
      bus.cur_ora = '0; bus.cur_min = '0; bus.alarm_ora = '0; bus.alarm_min = '0;
      repeat (2) @(posedge clock);

      step("reset",        1, NONE, 0, 0, 0, 0,  0,0,0,0);
      step("enter_t_ora",  0, L1,   0, 1, 12, 34, 0,0,0,0);
      for (int i = 1; i <= 12; i++)
         step("inc_ora",   0, S2,   0, 1, 5'((12 + i) % 24), 34, 0,0,0,0);
      step("abort",        0, L1,   0, 0, 0, 34,  0,0,0,0);

      cur_o = 5'd5; cur_m = 6'd0;
      step("enter_5_00",   0, L1,   0, 1, 5, 0,   0,0,0,0);
      step("to_t_min",     0, S1,   0, 2, 5, 0,   0,0,0,0);
      step("min_dec_wrap", 0, S3,   0, 2, 5, 59,  0,0,0,0);
      step("min_dec",      0, S3,   0, 2, 5, 58,  0,0,0,0);
      step("min_inc",      0, S2,   0, 2, 5, 59,  0,0,0,0);
      step("min_inc_wrap", 0, S2,   0, 2, 5, 0,   0,0,0,0);
      step("min_dec_wrap2",0, S3,   0, 2, 5, 59,  0,0,0,0);
      step("commit_time",  0, S1,   0, 0, 5, 59,  1,0,0,0);
      step("lt_one_cycle", 0, NONE, 0, 0, 5, 59,  0,0,0,0);

      cur_o = 5'd31; cur_m = 6'd63;
      step("clamp_load",   0, L1,   0, 1, 0, 0,   0,0,0,0);
      step("ora_dec_wrap", 0, S3,   0, 1, 23, 0,  0,0,0,0);
      step("ora_inc_wrap", 0, S2,   0, 1, 0, 0,   0,0,0,0);
      step("l2_ignored",   0, L2,   0, 1, 0, 0,   0,0,0,0);
      step("l3_drops_s2",  0, L3|S2,0, 1, 0, 0,   0,0,0,0);
      step("abort2",       0, L1,   0, 0, 0, 0,   0,0,0,0);

      step("enter_a_ora",  0, L2,   0, 3, 7, 0,   0,0,0,0);
      step("to_a_min",     0, S1,   0, 4, 7, 0,   0,0,0,0);
      step("commit_alarm", 0, S1,   0, 0, 7, 0,   0,1,1,0);
      step("la_one_cycle", 0, NONE, 0, 0, 7, 0,   0,0,1,0);

      step("stop_alarm",   0, S3,   1, 0, 7, 0,   0,0,1,1);
      step("sa_one_cycle", 0, NONE, 1, 0, 7, 0,   0,0,1,0);
      step("stop_on_l1",   0, L1,   1, 0, 7, 0,   0,0,1,1);
      step("toggle_off",   0, S3,   0, 0, 7, 0,   0,0,0,0);
      step("s1_drops_s3",  0, S1|S3,0, 0, 7, 0,   0,0,0,0);
      step("toggle_on",    0, S3,   0, 0, 7, 0,   0,0,1,0);

      cur_o = 5'd12; cur_m = 6'd34;
      step("enter_again",  0, L1,   0, 1, 12, 34, 0,0,1,0);
      step("suna_in_set",  0, S2,   1, 1, 13, 34, 0,0,1,0);
      step("to_t_min2",    0, S1,   0, 2, 13, 34, 0,0,1,0);
      step("abort_beats_commit", 0, L1|S1, 0, 0, 13, 34, 0,0,1,0);
      step("hold_normal",  0, NONE, 0, 0, 13, 34, 0,0,1,0);

      step("enter3",       0, L1,   0, 1, 12, 34, 0,0,1,0);
      step("reset_mid_edit",1, S1,  0, 0, 0, 0,   0,0,0,0);
      step("after_reset",  0, NONE, 0, 0, 0, 0,   0,0,0,0);

      step("enter_idle",   0, L1,   0, 1, 12, 34, 0,0,0,0);
      for (int k = 1; k <= 16; k++) begin
`ifdef SETARE_TIMEOUT_EN
         step("idle_set",  0, NONE, 0, (k == 16) ? 3'd0 : 3'd1, 12, 34, 0,0,0,0);
`else
         step("idle_set",  0, NONE, 0, 1, 12, 34, 0,0,0,0);
`endif
      end

      repeat (3) @(posedge clock);
      #2;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
